// File: rtl/acc_pkg.sv
// Shared opcode encoding for the accumulator/stack unit.
// ROL/ROR (0xA/0xB) are only implemented when ACC_ROTATE_EN is defined.
package acc_pkg;

  localparam int unsigned ACC_OP_W = 4;

  typedef enum logic [ACC_OP_W-1:0] {
    OpNop    = 4'h0,
    OpLoad   = 4'h1,
    OpClr    = 4'h2,
    OpInc    = 4'h3,
    OpDec    = 4'h4,
    OpShl    = 4'h5,
    OpShr    = 4'h6,
    OpPush   = 4'h7,
    OpPop    = 4'h8,
    OpSwap   = 4'h9,
    OpRol    = 4'hA,
    OpRor    = 4'hB,
    OpClrErr = 4'hF
  } acc_op_e;

endpackage

// File: rtl/acc_stack_unit_if.sv
// Operation/bus interface of the accumulator unit. master drives opcodes and send,
// slave is the accumulator unit itself.
interface acc_stack_unit_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  import acc_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic             op_valid;
  acc_op_e          op;
  logic [WIDTH-1:0] bus_in;
  logic             send;
  logic [WIDTH-1:0] acc_out;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic             zero;
  logic             neg;
  logic             carry;
  logic [CntW-1:0]  stk_count;
  logic             stk_full;
  logic             stk_empty;
  logic             err;

  modport master (
    output op_valid, op, bus_in, send,
    input  acc_out, bus_out, bus_oe, zero, neg, carry, stk_count, stk_full, stk_empty, err
  );

  modport slave (
    input  op_valid, op, bus_in, send,
    output acc_out, bus_out, bus_oe, zero, neg, carry, stk_count, stk_full, stk_empty, err
  );

endinterface

// File: rtl/acc_lifo.sv
// DEPTH-entry save stack for the accumulator. Callers only request legal ops,
// but push/pop/swap are still guarded against full/empty here.
module acc_lifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         swap_i,
  input  logic [WIDTH-1:0]             wdata_i,
  output logic [WIDTH-1:0]             top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CntW-1:0]  count_q, count_d;
  logic [IdxW-1:0]  wr_idx, top_idx;
  logic             full, empty;

  assign full    = (count_q == CntW'(DEPTH));
  assign empty   = (count_q == '0);
  assign wr_idx  = IdxW'(count_q);
  assign top_idx = IdxW'(count_q - 1'b1);

  // Occupancy count follows accepted push/pop requests.
  always_comb begin
    count_d = count_q;
    if (push_i && !full) begin
      count_d = count_q + 1'b1;
    end else if (pop_i && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register; stack contents are intentionally left unreset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Storage writes: push fills the next free slot, swap overwrites the top.
  always_ff @(posedge clk_i) begin
    if (push_i && !full) begin
      mem_q[wr_idx] <= wdata_i;
    end else if (swap_i && !empty) begin
      mem_q[top_idx] <= wdata_i;
    end
  end

  assign top_o   = empty ? '0 : mem_q[top_idx];
  assign count_o = count_q;
  assign full_o  = full;
  assign empty_o = empty;

endmodule

// File: rtl/acc_stack_unit.sv
// Accumulator with carry/zero/negative flags, sticky error flag and save stack.
// Optional feature macro: ACC_ROTATE_EN enables ROL/ROR through carry; without it
// opcodes 0xA/0xB are illegal.
module acc_stack_unit
  import acc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  acc_stack_unit_if.slave acc_if
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             err_q, err_d;
  logic             push, pop, swap;
  logic [WIDTH-1:0] stk_top;
  logic [CntW-1:0]  stk_count;
  logic             stk_full, stk_empty;

  acc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .pop_i   (pop),
    .swap_i  (swap),
    .wdata_i (acc_q),
    .top_o   (stk_top),
    .count_o (stk_count),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  // Opcode decode; an op that errors leaves acc, carry and stack untouched.
  always_comb begin
    acc_d   = acc_q;
    carry_d = carry_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    swap    = 1'b0;
    if (acc_if.op_valid) begin
      unique case (acc_if.op)
        OpNop:  ;
        OpLoad: acc_d = acc_if.bus_in;
        OpClr: begin
          acc_d   = '0;
          carry_d = 1'b0;
        end
        OpInc:  {carry_d, acc_d} = {1'b0, acc_q} + (WIDTH + 1)'(1);
        OpDec: begin
          acc_d   = acc_q - WIDTH'(1);
          carry_d = (acc_q == '0);
        end
        OpShl: begin
          carry_d = acc_q[WIDTH-1];
          acc_d   = {acc_q[WIDTH-2:0], 1'b0};
        end
        OpShr: begin
          carry_d = acc_q[0];
          acc_d   = {1'b0, acc_q[WIDTH-1:1]};
        end
        OpPush: begin
          if (stk_full) err_d = 1'b1;
          else          push  = 1'b1;
        end
        OpPop: begin
          if (stk_empty) begin
            err_d = 1'b1;
          end else begin
            pop   = 1'b1;
            acc_d = stk_top;
          end
        end
        OpSwap: begin
          if (stk_empty) begin
            err_d = 1'b1;
          end else begin
            swap  = 1'b1;
            acc_d = stk_top;
          end
        end
`ifdef ACC_ROTATE_EN
        OpRol:  {carry_d, acc_d} = {acc_q, carry_q};
        OpRor:  {acc_d, carry_d} = {carry_q, acc_q};
`endif
        OpClrErr: err_d = 1'b0;
        default:  err_d = 1'b1;
      endcase
    end
  end

  // Accumulator and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  assign acc_if.acc_out   = acc_q;
  assign acc_if.zero      = (acc_q == '0);
  assign acc_if.neg       = acc_q[WIDTH-1];
  assign acc_if.carry     = carry_q;
  assign acc_if.err       = err_q;
  assign acc_if.bus_out   = acc_if.send ? acc_q : '0;
  assign acc_if.bus_oe    = acc_if.send;
  assign acc_if.stk_count = stk_count;
  assign acc_if.stk_full  = stk_full;
  assign acc_if.stk_empty = stk_empty;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Directed self-checking bench for acc_stack_unit (WIDTH=8, DEPTH=4).
module tb_acc_stack_unit;
  import acc_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  acc_stack_unit_if #(.WIDTH(8), .DEPTH(4)) acc_if ();

  acc_stack_unit #(
    .WIDTH (8),
    .DEPTH (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .acc_if (acc_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single rising edge; returns on the following falling edge.
  task automatic do_op(input acc_op_e o, input logic [7:0] d);
    @(negedge clk);
    acc_if.op_valid = 1'b1;
    acc_if.op       = o;
    acc_if.bus_in   = d;
    @(negedge clk);
    acc_if.op_valid = 1'b0;
    acc_if.op       = OpNop;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    acc_if.op_valid = 1'b0;
    acc_if.op       = OpNop;
    acc_if.bus_in   = 8'h00;
    acc_if.send     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_acc",   acc_if.acc_out, 8'h00);
    check("rst_carry", acc_if.carry, 1'b0);
    check("rst_zero",  acc_if.zero, 1'b1);
    check("rst_neg",   acc_if.neg, 1'b0);
    check("rst_count", acc_if.stk_count, 3'd0);
    check("rst_empty", acc_if.stk_empty, 1'b1);
    check("rst_err",   acc_if.err, 1'b0);

    // op_valid low: LOAD must be ignored
    @(negedge clk);
    acc_if.op = OpLoad;
    acc_if.bus_in = 8'h5A;
    @(negedge clk);
    acc_if.op = OpNop;
    check("nop_when_invalid", acc_if.acc_out, 8'h00);

    do_op(OpLoad, 8'h7F);
    check("load_7f", acc_if.acc_out, 8'h7F);
    do_op(OpInc, 8'h00);
    check("inc_80_acc",   acc_if.acc_out, 8'h80);
    check("inc_80_neg",   acc_if.neg, 1'b1);
    check("inc_80_carry", acc_if.carry, 1'b0);
    for (int i = 0; i < 127; i++) do_op(OpInc, 8'h00);
    check("inc_ff_acc",   acc_if.acc_out, 8'hFF);
    check("inc_ff_carry", acc_if.carry, 1'b0);
    do_op(OpInc, 8'h00);
    check("inc_wrap_acc",   acc_if.acc_out, 8'h00);
    check("inc_wrap_zero",  acc_if.zero, 1'b1);
    check("inc_wrap_carry", acc_if.carry, 1'b1);

    do_op(OpClr, 8'h00);
    check("clr_carry", acc_if.carry, 1'b0);
    do_op(OpDec, 8'h00);
    check("dec_wrap_acc",   acc_if.acc_out, 8'hFF);
    check("dec_wrap_carry", acc_if.carry, 1'b1);
    do_op(OpShr, 8'h00);
    check("shr_acc",   acc_if.acc_out, 8'h7F);
    check("shr_carry", acc_if.carry, 1'b1);
    do_op(OpShl, 8'h00);
    check("shl_acc",   acc_if.acc_out, 8'hFE);
    check("shl_carry", acc_if.carry, 1'b0);
    do_op(OpDec, 8'h00);
    check("dec_acc",   acc_if.acc_out, 8'hFD);
    check("dec_carry", acc_if.carry, 1'b0);

    // Fill the stack
    do_op(OpLoad, 8'h11); do_op(OpPush, 8'h00);
    do_op(OpLoad, 8'h22); do_op(OpPush, 8'h00);
    check("push_count2", acc_if.stk_count, 3'd2);
    do_op(OpLoad, 8'h33); do_op(OpPush, 8'h00);
    do_op(OpLoad, 8'h44); do_op(OpPush, 8'h00);
    check("full_flag",  acc_if.stk_full, 1'b1);
    check("full_count", acc_if.stk_count, 3'd4);
    check("push_acc_kept", acc_if.acc_out, 8'h44);
    check("push_no_err", acc_if.err, 1'b0);
    do_op(OpLoad, 8'h55); do_op(OpPush, 8'h00);
    check("overflow_err",   acc_if.err, 1'b1);
    check("overflow_count", acc_if.stk_count, 3'd4);
    do_op(OpPop, 8'h00);
    check("pop1", acc_if.acc_out, 8'h44);
    do_op(OpPop, 8'h00);
    check("pop2", acc_if.acc_out, 8'h33);
    do_op(OpPop, 8'h00);
    check("pop3", acc_if.acc_out, 8'h22);
    do_op(OpPop, 8'h00);
    check("pop4",       acc_if.acc_out, 8'h11);
    check("pop_empty",  acc_if.stk_empty, 1'b1);
    check("pop_carry",  acc_if.carry, 1'b0);

    do_op(OpClrErr, 8'h00);
    check("clrerr1", acc_if.err, 1'b0);
    do_op(OpPop, 8'h00);
    check("underflow_err", acc_if.err, 1'b1);
    check("underflow_acc", acc_if.acc_out, 8'h11);
    do_op(OpClrErr, 8'h00);
    check("clrerr2", acc_if.err, 1'b0);
    do_op(acc_op_e'(4'hC), 8'h00);
    check("illegal_c_err", acc_if.err, 1'b1);
    check("illegal_c_acc", acc_if.acc_out, 8'h11);
    do_op(OpNop, 8'h00);
    check("err_sticky", acc_if.err, 1'b1);
    do_op(OpClrErr, 8'h00);
    do_op(OpSwap, 8'h00);
    check("swap_empty_err", acc_if.err, 1'b1);
    check("swap_empty_acc", acc_if.acc_out, 8'h11);
    do_op(OpClrErr, 8'h00);

    // SWAP and bus drive
    do_op(OpLoad, 8'h55); do_op(OpPush, 8'h00);
    do_op(OpLoad, 8'hAA); do_op(OpSwap, 8'h00);
    check("swap_acc",   acc_if.acc_out, 8'h55);
    check("swap_count", acc_if.stk_count, 3'd1);
    acc_if.send = 1'b1;
    #1;
    check("bus_out_on", acc_if.bus_out, 8'h55);
    check("bus_oe_on",  acc_if.bus_oe, 1'b1);
    acc_if.send = 1'b0;
    #1;
    check("bus_out_off", acc_if.bus_out, 8'h00);
    check("bus_oe_off",  acc_if.bus_oe, 1'b0);
    do_op(OpPop, 8'h00);
    check("swap_top", acc_if.acc_out, 8'hAA);
    check("swap_no_err", acc_if.err, 1'b0);

    // Rotate: set carry=1 then acc=0x80
    do_op(OpLoad, 8'hFF); do_op(OpInc, 8'h00);
    do_op(OpLoad, 8'h80);
    check("pre_rol_carry", acc_if.carry, 1'b1);
    do_op(OpRol, 8'h00);
`ifdef ACC_ROTATE_EN
    check("rol_acc",   acc_if.acc_out, 8'h01);
    check("rol_carry", acc_if.carry, 1'b1);
    check("rol_err",   acc_if.err, 1'b0);
    do_op(OpRor, 8'h00);
    check("ror_acc",   acc_if.acc_out, 8'h80);
    check("ror_carry", acc_if.carry, 1'b1);
`else
    check("rol_off_acc", acc_if.acc_out, 8'h80);
    check("rol_off_err", acc_if.err, 1'b1);
    do_op(OpClrErr, 8'h00);
    do_op(OpRor, 8'h00);
    check("ror_off_acc", acc_if.acc_out, 8'h80);
    check("ror_off_err", acc_if.err, 1'b1);
`endif

    // Reset asserted while a PUSH is pending
    do_op(OpPush, 8'h00);
    check("pre_reset_count", acc_if.stk_count, 3'd1);
    @(negedge clk);
    acc_if.op_valid = 1'b1;
    acc_if.op       = OpPush;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_count", acc_if.stk_count, 3'd0);
    check("midrst_acc",   acc_if.acc_out, 8'h00);
    check("midrst_carry", acc_if.carry, 1'b0);
    check("midrst_err",   acc_if.err, 1'b0);
    @(negedge clk);
    acc_if.op_valid = 1'b0;
    acc_if.op       = OpNop;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_count", acc_if.stk_count, 3'd0);
    check("postrst_zero",  acc_if.zero, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
